sram_ctrl: RTL and testbench

Synchronous bus bridge that sits directly upstream of the 2 KB asynchronous work SRAM: it accepts single-clock read/write requests from the 6502 bus side and generates the SRAM pin sequence. The pin sequence covers address setup, output-enable window, rising-edge write strobe, hold, and data-bus turnaround. The controller serialises one access at a time and returns read data (or write completion) as a one-cycle response pulse.

---
 rtl/sram_ctrl_pkg.sv | 23 ++
 rtl/sram_ctrl_if.sv | 27 ++
 rtl/sram_phase_cnt.sv | 33 +++
 rtl/sram_ctrl.sv | 149 ++++++++++++++
 tb/tb_sram_ctrl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the 6502-side work-SRAM controller.
// Optional read-after-write forwarding is enabled by defining SRAM_CTRL_RAW_FWD_EN.
package sram_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 11;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [2:0] {
        StIdle,
        StWSetup,
        StWStrobe,
        StWHold,
        StRSetup,
        StRSample
    } state_e;

    // Phase lengths are 1..15 cycles; the counter runs from len-1 down to 0.
    function automatic logic [CNT_W-1:0] phase_load(input int unsigned cyc);
        return CNT_W'(cyc - 1);
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Request/response handshake between the 6502 bus side and sram_ctrl.
interface sram_ctrl_if
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/sram_phase_cnt.sv
// Loadable down-counter timing each SRAM phase; done is high while the count is zero.
module sram_phase_cnt
    import sram_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// Serialising bridge from single-cycle bus requests to the async work-SRAM pin sequence.
// Define SRAM_CTRL_RAW_FWD_EN to answer reads of the last written address without an access.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 1,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned READ_CYC   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_ctrl_if.slave        bus,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_data,
    output logic              sram_w,
    output logic              sram_oe
);

    state_e            state_q, state_d;
    logic              cnt_load, cnt_done;
    logic [CNT_W-1:0]  cnt_val;
    logic              accept, fwd_hit;
    logic [DATA_W-1:0] fwd_rdata;
    logic              rsp_valid_d;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              sram_w_q, sram_oe_q, drive_q;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q;

    assign accept = bus.req_valid && (state_q == StIdle);

`ifdef SRAM_CTRL_RAW_FWD_EN
    logic              fwd_valid_q;
    logic [ADDR_W-1:0] fwd_addr_q;
    logic [DATA_W-1:0] fwd_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= '0;
        end else if (accept && bus.req_we) begin
            fwd_valid_q <= 1'b1;
            fwd_addr_q  <= bus.req_addr;
            fwd_data_q  <= bus.req_wdata;
        end
    end

    assign fwd_hit   = accept && !bus.req_we && fwd_valid_q && (bus.req_addr == fwd_addr_q);
    assign fwd_rdata = fwd_data_q;
`else
    assign fwd_hit   = 1'b0;
    assign fwd_rdata = '0;
`endif

    always_comb begin
        state_d     = state_q;
        rsp_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept && !fwd_hit) begin
                    state_d = bus.req_we ? StWSetup : StRSetup;
                end
                rsp_valid_d = fwd_hit;
            end
            StWSetup:  if (cnt_done) state_d = StWStrobe;
            StWStrobe: if (cnt_done) state_d = StWHold;
            StWHold: begin
                if (cnt_done) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b1;
                end
            end
            StRSetup:  if (cnt_done) state_d = StRSample;
            StRSample: begin
                if (cnt_done) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_val = '0;
        case (state_d)
            StWSetup, StRSetup: cnt_val = phase_load(SETUP_CYC);
            StWStrobe:          cnt_val = phase_load(STROBE_CYC);
            StWHold:            cnt_val = phase_load(HOLD_CYC);
            StRSample:          cnt_val = phase_load(READ_CYC);
            default:            cnt_val = '0;
        endcase
    end

    // Every state change reloads the counter with the new phase length.
    assign cnt_load = (state_d != state_q);

    sram_phase_cnt u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .done     (cnt_done)
    );

    // Pin controls are decoded from the next state so they change cleanly on clock edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            sram_w_q    <= 1'b0;
            sram_oe_q   <= 1'b0;
            drive_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            sram_w_q    <= (state_d == StWStrobe);
            sram_oe_q   <= (state_d inside {StRSetup, StRSample});
            drive_q     <= (state_d inside {StWSetup, StWStrobe, StWHold});
            rsp_valid_q <= rsp_valid_d;
            if (accept && !fwd_hit) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
            if (fwd_hit) begin
                rsp_rdata_q <= fwd_rdata;
            end else if (state_q == StRSample && cnt_done) begin
                rsp_rdata_q <= sram_data;
            end
        end
    end

    assign sram_addr     = addr_q;
    assign sram_w        = sram_w_q;
    assign sram_oe       = sram_oe_q;
    assign sram_data     = drive_q ? wdata_q : {DATA_W{1'bz}};
    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural async SRAM on the pins.
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] sram_addr;
    wire  [7:0]  sram_data;
    logic        sram_w;
    logic        sram_oe;

    int n_run  = 0;
    int n_fail = 0;
    int both_hi = 0;

    sram_ctrl_if bus_if ();

    sram_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if.slave),
        .sram_addr (sram_addr),
        .sram_data (sram_data),
        .sram_w    (sram_w),
        .sram_oe   (sram_oe)
    );

    always #5 clk = ~clk;

    // SRAM model: unwritten locations read back addr[7:0] ^ 8'h96.
    logic [7:0] mem [2048];
    bit         written [2048];
    always @(posedge sram_w) begin
        mem[sram_addr]     = sram_data;
        written[sram_addr] = 1'b1;
    end
    assign sram_data = sram_oe ? (written[sram_addr] ? mem[sram_addr]
                                                     : (sram_addr[7:0] ^ 8'h96)) : 8'hzz;

    always @(negedge clk) if (sram_w && sram_oe) both_hi++;

    logic       c_w [0:9];
    logic       c_oe [0:9];
    logic       c_rv [0:9];
    logic       c_rdy [0:9];
    logic [10:0] c_addr [0:9];
    logic [7:0] c_data [0:9];
    logic [7:0] c_rd [0:9];

    task automatic capture(input int from, input int to);
        for (int k = from; k <= to; k++) begin
            @(negedge clk);
            c_w[k]    = sram_w;
            c_oe[k]   = sram_oe;
            c_rv[k]   = bus_if.rsp_valid;
            c_rdy[k]  = bus_if.req_ready;
            c_addr[k] = sram_addr;
            c_data[k] = sram_data;
            c_rd[k]   = bus_if.rsp_rdata;
        end
    endtask

    // Presents a request for one cycle; returns req_ready seen in the accept cycle.
    task automatic issue(input logic we, input logic [10:0] addr, input logic [7:0] wdata,
                         output logic rdy0);
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = we;
        bus_if.req_addr  = addr;
        bus_if.req_wdata = wdata;
        @(negedge clk);
        rdy0 = bus_if.req_ready;
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_run++; if (sram_w !== 1'b0) begin n_fail++; $display("FAIL rst_w got %b want 0", sram_w); end
        n_run++; if (sram_oe !== 1'b0) begin n_fail++; $display("FAIL rst_oe got %b want 0", sram_oe); end
        n_run++;
        if (bus_if.rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_rsp_valid got %b want 0", bus_if.rsp_valid);
        end
        n_run++; if (sram_addr !== 11'h000) begin n_fail++; $display("FAIL rst_addr got %h want 000", sram_addr); end
        n_run++;
        if (bus_if.rsp_rdata !== 8'h00) begin
            n_fail++; $display("FAIL rst_rdata got %h want 00", bus_if.rsp_rdata);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        n_run++;
        if (bus_if.req_ready !== 1'b1) begin
            n_fail++; $display("FAIL rst_ready got %b want 1", bus_if.req_ready);
        end
    endtask

    task automatic test_write;
        logic rdy0;
        int   rises;
        issue(1'b1, 11'h123, 8'h5A, rdy0);
        capture(1, 6);
        n_run++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL wr_accept_ready got %b want 1", rdy0); end
        rises = 0;
        for (int k = 1; k <= 6; k++) begin
            if (c_w[k] && (k == 1 || !c_w[k-1])) rises++;
            n_run++;
            if (c_w[k] !== (k == 2)) begin
                n_fail++; $display("FAIL wr_strobe c%0d got %b want %b", k, c_w[k], k == 2);
            end
            n_run++;
            if (c_rv[k] !== (k == 4)) begin
                n_fail++; $display("FAIL wr_rsp_valid c%0d got %b want %b", k, c_rv[k], k == 4);
            end
            n_run++;
            if (c_rdy[k] !== (k >= 4)) begin
                n_fail++; $display("FAIL wr_ready c%0d got %b want %b", k, c_rdy[k], k >= 4);
            end
            n_run++; if (c_oe[k] !== 1'b0) begin n_fail++; $display("FAIL wr_oe c%0d got 1 want 0", k); end
            if (k <= 3) begin
                n_run++;
                if (c_addr[k] !== 11'h123 || c_data[k] !== 8'h5A) begin
                    n_fail++;
                    $display("FAIL wr_addr_data c%0d got %h/%h want 123/5a", k, c_addr[k], c_data[k]);
                end
            end
        end
        n_run++; if (rises != 1) begin n_fail++; $display("FAIL wr_rise_count got %0d want 1", rises); end
        n_run++;
        if (!written[11'h123] || mem[11'h123] !== 8'h5A) begin
            n_fail++; $display("FAIL wr_landed got %h want 5a", mem[11'h123]);
        end
    endtask

    task automatic test_read;
        logic rdy0;
        issue(1'b0, 11'h123, 8'h00, rdy0);
        capture(1, 6);
        for (int k = 1; k <= 6; k++) begin
            n_run++;
            if (c_oe[k] !== (k <= 3)) begin
                n_fail++; $display("FAIL rd_oe c%0d got %b want %b", k, c_oe[k], k <= 3);
            end
            n_run++;
            if (c_rv[k] !== (k == 4)) begin
                n_fail++; $display("FAIL rd_rsp_valid c%0d got %b want %b", k, c_rv[k], k == 4);
            end
            n_run++; if (c_w[k] !== 1'b0) begin n_fail++; $display("FAIL rd_w c%0d got 1 want 0", k); end
        end
        n_run++; if (c_rd[4] !== 8'h5A) begin n_fail++; $display("FAIL rd_data got %h want 5a", c_rd[4]); end
        n_run++; if (c_rd[6] !== 8'h5A) begin n_fail++; $display("FAIL rd_hold got %h want 5a", c_rd[6]); end
        n_run++; if (c_addr[2] !== 11'h123) begin n_fail++; $display("FAIL rd_addr got %h want 123", c_addr[2]); end
    endtask

    task automatic test_back_to_back;
        logic rdy0;
        both_hi = 0;
        issue(1'b0, 11'h7FF, 8'h00, rdy0);
        capture(1, 3);
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = 1'b1;
        bus_if.req_addr  = 11'h000;
        bus_if.req_wdata = 8'hFF;
        capture(4, 4);
        @(posedge clk);
        #1;
        bus_if.req_valid = 1'b0;
        capture(5, 9);
        for (int k = 1; k <= 3; k++) begin
            n_run++; if (c_oe[k] !== 1'b1) begin n_fail++; $display("FAIL b2b_oe c%0d got 0 want 1", k); end
        end
        n_run++;
        if (c_rv[4] !== 1'b1 || c_rd[4] !== 8'h69) begin
            n_fail++; $display("FAIL b2b_rd got %b/%h want 1/69", c_rv[4], c_rd[4]);
        end
        n_run++; if (c_rdy[4] !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got 0 want 1"); end
        n_run++; if (c_oe[4] !== 1'b0) begin n_fail++; $display("FAIL b2b_oe_fall got 1 want 0"); end
        n_run++;
        if (c_data[4] === 8'hFF) begin
            n_fail++; $display("FAIL b2b_turnaround got ff driven in cycle after oe, want z");
        end
        n_run++;
        if (c_data[5] !== 8'hFF || c_addr[5] !== 11'h000) begin
            n_fail++; $display("FAIL b2b_wr_drive got %h/%h want 000/ff", c_addr[5], c_data[5]);
        end
        n_run++; if (c_w[6] !== 1'b1) begin n_fail++; $display("FAIL b2b_strobe got 0 want 1"); end
        n_run++;
        if (c_rv[8] !== 1'b1 || c_rv[7] !== 1'b0) begin
            n_fail++; $display("FAIL b2b_wr_rsp got c7=%b c8=%b want 0/1", c_rv[7], c_rv[8]);
        end
        n_run++; if (both_hi != 0) begin n_fail++; $display("FAIL b2b_w_and_oe got %0d want 0", both_hi); end
    endtask

    task automatic test_reset_wstrobe;
        logic rdy0;
        issue(1'b1, 11'h055, 8'hC3, rdy0);
        @(negedge clk);
        @(negedge clk);
        n_run++; if (sram_w !== 1'b1) begin n_fail++; $display("FAIL rws_strobe got 0 want 1"); end
        #2 rst_n = 1'b0;
        #1;
        n_run++; if (sram_w !== 1'b0) begin n_fail++; $display("FAIL rws_async_w got 1 want 0"); end
        @(negedge clk) rst_n = 1'b1;
        capture(1, 5);
        for (int k = 1; k <= 5; k++) begin
            n_run++; if (c_rv[k] !== 1'b0) begin n_fail++; $display("FAIL rws_no_rsp c%0d got 1", k); end
        end
        issue(1'b0, 11'h123, 8'h00, rdy0);
        capture(1, 5);
        n_run++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL rws_next_ready got 0 want 1"); end
        n_run++;
        if (c_rv[4] !== 1'b1 || c_rd[4] !== 8'h5A) begin
            n_fail++; $display("FAIL rws_next_read got %b/%h want 1/5a", c_rv[4], c_rd[4]);
        end
    endtask

    task automatic test_fwd;
        logic rdy0;
        issue(1'b1, 11'h010, 8'h3C, rdy0);
        capture(1, 6);
        issue(1'b0, 11'h010, 8'h00, rdy0);
        capture(1, 6);
`ifdef SRAM_CTRL_RAW_FWD_EN
        n_run++;
        if (c_rv[1] !== 1'b1 || c_rd[1] !== 8'h3C) begin
            n_fail++; $display("FAIL fwd_hit got %b/%h want 1/3c", c_rv[1], c_rd[1]);
        end
        n_run++; if (c_rdy[1] !== 1'b1) begin n_fail++; $display("FAIL fwd_ready got 0 want 1"); end
        n_run++; if (c_rv[2] !== 1'b0) begin n_fail++; $display("FAIL fwd_pulse got 1 want 0"); end
        for (int k = 1; k <= 6; k++) begin
            n_run++; if (c_oe[k] !== 1'b0) begin n_fail++; $display("FAIL fwd_no_oe c%0d got 1", k); end
        end
`else
        n_run++;
        if (c_rv[4] !== 1'b1 || c_rd[4] !== 8'h3C) begin
            n_fail++; $display("FAIL raw_read got %b/%h want 1/3c", c_rv[4], c_rd[4]);
        end
        n_run++; if (c_oe[2] !== 1'b1) begin n_fail++; $display("FAIL raw_oe got 0 want 1"); end
`endif
        issue(1'b0, 11'h011, 8'h00, rdy0);
        capture(1, 6);
        for (int k = 1; k <= 5; k++) begin
            n_run++;
            if (c_oe[k] !== (k <= 3)) begin
                n_fail++; $display("FAIL miss_oe c%0d got %b want %b", k, c_oe[k], k <= 3);
            end
            n_run++;
            if (c_rv[k] !== (k == 4)) begin
                n_fail++; $display("FAIL miss_rsp c%0d got %b want %b", k, c_rv[k], k == 4);
            end
        end
        n_run++; if (c_rd[4] !== 8'h87) begin n_fail++; $display("FAIL miss_data got %h want 87", c_rd[4]); end
    endtask

    initial begin
        bus_if.req_valid = 1'b0;
        bus_if.req_we    = 1'b0;
        bus_if.req_addr  = '0;
        bus_if.req_wdata = '0;
        test_reset;
        test_write;
        test_read;
        test_back_to_back;
        test_reset_wstrobe;
        test_fwd;
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
